// File: rtl/axi_lite_regfile_slave_if.sv
// AXI-Lite bus bundle for the register-file slave: all five channels,
// with master and slave views.
interface axi_lite_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite slave mapping NUM_REGS byte-strobed registers; exports all register
// contents and a per-register write pulse. Every bus output is registered.
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi_lite_regfile_slave_if.slave        bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_reg;

    w_state_e              w_state_reg, w_state_next;
    logic                  aw_held_reg, aw_held_next;
    logic                  w_held_reg, w_held_next;
    logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0]     wstrb_reg, wstrb_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;

    r_state_e              r_state_reg, r_state_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]            rresp_reg, rresp_next;

    logic                  aw_hs, w_hs, commit, reg_wr;
    logic [ADDR_WIDTH-1:0] cur_awaddr, wr_word, rd_word;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_W-1:0]     cur_wstrb;
    logic                  wr_ok, rd_ok;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    // A word index below NUM_REGS implies every address bit above the index is zero.
    always_comb begin
        aw_hs      = bus.AWVALID && awready_reg;
        w_hs       = bus.WVALID && wready_reg;
        cur_awaddr = aw_hs ? bus.AWADDR : awaddr_reg;
        cur_wdata  = w_hs ? bus.WDATA : wdata_reg;
        cur_wstrb  = w_hs ? bus.WSTRB : wstrb_reg;
        wr_word    = cur_awaddr >> ADDR_LSB;
        wr_ok      = wr_word < ADDR_WIDTH'(NUM_REGS);
        wr_idx     = wr_word[IDX_W-1:0];
        rd_word    = bus.ARADDR >> ADDR_LSB;
        rd_ok      = rd_word < ADDR_WIDTH'(NUM_REGS);
        rd_idx     = rd_word[IDX_W-1:0];
        commit     = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
        reg_wr     = commit && wr_ok;
    end

    always_comb begin
        w_state_next = w_state_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    awaddr_next  = bus.AWADDR;
                    aw_held_next = 1'b1;
                end
                if (w_hs) begin
                    wdata_next  = bus.WDATA;
                    wstrb_next  = bus.WSTRB;
                    w_held_next = 1'b1;
                end
                if (commit) begin
                    w_state_next = W_RESP;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                    bresp_next   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    awready_next = !(aw_held_reg || aw_hs);
                    wready_next  = !(w_held_reg || w_hs);
                end
            end
            W_RESP: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
                // First W_RESP cycle carries the write pulse; BVALID follows a cycle later.
                if (!bvalid_reg) begin
                    bvalid_next = 1'b1;
                end else if (bus.BREADY) begin
                    bvalid_next  = 1'b0;
                    w_state_next = W_IDLE;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (bus.ARVALID && arready_reg) begin
                    arready_next = 1'b0;
                    rvalid_next  = 1'b1;
                    rdata_next   = rd_ok ? regs_reg[rd_idx] : '0;
                    rresp_next   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.RREADY) begin
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= 2'b00;
        end else begin
            w_state_reg <= w_state_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            awaddr_reg  <= awaddr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= '0;
            end
            wr_pulse_reg <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                wr_pulse_reg[r] <= reg_wr && (wr_idx == IDX_W'(r));
                if (reg_wr && (wr_idx == IDX_W'(r))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (cur_wstrb[b]) begin
                            regs_reg[r][b*8 +: 8] <= cur_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign wr_pulse    = wr_pulse_reg;
    assign bus.AWREADY = awready_reg;
    assign bus.WREADY  = wready_reg;
    assign bus.BVALID  = bvalid_reg;
    assign bus.BRESP   = bresp_reg;
    assign bus.ARREADY = arready_reg;
    assign bus.RVALID  = rvalid_reg;
    assign bus.RDATA   = rdata_reg;
    assign bus.RRESP   = rresp_reg;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench for axi_lite_regfile_slave: directed scenarios followed by
// randomized writes/reads checked against an array model of the register bank.
module tb_axi_lite_regfile_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    always #5 ACLK = ~ACLK;

    axi_lite_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .bus      (bus),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model [NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // 16 word registers occupy byte addresses 0x00..0x3F; anything else is an error.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:6] == 26'd0) && (int'(a[5:2]) < NR);
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s reg_out[%0d]", tag, i), reg_out[i*DW +: DW], model[i]);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bready_dly);
        logic aw_done = 1'b0;
        logic w_done  = 1'b0;
        int   n = 0;
        logic ok = addr_ok(addr);
        logic [NR-1:0] exp_pulse = ok ? (NR'(1) << addr[5:2]) : '0;
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (w_done && !aw_done) check("wready_low_after_w", bus.WREADY, 0);
            if (aw_done && !w_done) check("awready_low_after_aw", bus.AWREADY, 0);
            bus.AWADDR  = addr;
            bus.WDATA   = data;
            bus.WSTRB   = strb;
            bus.AWVALID = !aw_done && (n >= aw_dly);
            bus.WVALID  = !w_done && (n >= w_dly);
            if (bus.AWVALID && bus.AWREADY) aw_done = 1'b1;
            if (bus.WVALID && bus.WREADY) w_done = 1'b1;
            n++;
            if (n > 40) begin
                check("write_handshake_timeout", 0, 1);
                bus.AWVALID = 1'b0;
                bus.WVALID  = 1'b0;
                return;
            end
        end
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (ok)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
        check("wr_pulse", wr_pulse, exp_pulse);
        check("bvalid_not_yet", bus.BVALID, 0);
        check("awready_after_commit", bus.AWREADY, 0);
        check("wready_after_commit", bus.WREADY, 0);
        @(negedge ACLK);
        check("bvalid", bus.BVALID, 1);
        check("bresp", bus.BRESP, ok ? 2'b00 : 2'b10);
        check("wr_pulse_single", wr_pulse, 0);
        check_regs("after_write");
        $display("write addr=0x%08h data=0x%08h strb=0x%0h resp=%0d", addr, data, strb, bus.BRESP);
        if (bready_dly < 0) return;
        for (int k = 0; k < bready_dly; k++) begin
            bus.BREADY = 1'b0;
            @(negedge ACLK);
            check("bvalid_hold", bus.BVALID, 1);
            check("bresp_hold", bus.BRESP, ok ? 2'b00 : 2'b10);
            check("awready_hold", bus.AWREADY, 0);
            check("wready_hold", bus.WREADY, 0);
        end
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        check("bvalid_drop", bus.BVALID, 0);
        check("awready_back", bus.AWREADY, 1);
        check("wready_back", bus.WREADY, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rready_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int n = 0;
        bus.ARADDR = addr;
        forever begin
            @(negedge ACLK);
            bus.ARVALID = 1'b1;
            if (bus.ARREADY) break;
            n++;
            if (n > 40) begin
                check("read_handshake_timeout", 0, 1);
                bus.ARVALID = 1'b0;
                return;
            end
        end
        exp_data = addr_ok(addr) ? model[addr[5:2]] : 32'd0;
        exp_resp = addr_ok(addr) ? 2'b00 : 2'b10;
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        check("rvalid", bus.RVALID, 1);
        check("rdata", bus.RDATA, exp_data);
        check("rresp", bus.RRESP, exp_resp);
        check("arready_busy", bus.ARREADY, 0);
        $display("read  addr=0x%08h data=0x%08h resp=%0d", addr, bus.RDATA, bus.RRESP);
        if (rready_dly < 0) return;
        for (int k = 0; k < rready_dly; k++) begin
            bus.RREADY = 1'b0;
            @(negedge ACLK);
            check("rvalid_hold", bus.RVALID, 1);
            check("rdata_hold", bus.RDATA, exp_data);
        end
        bus.RREADY = 1'b1;
        @(negedge ACLK);
        bus.RREADY = 1'b0;
        check("rvalid_drop", bus.RVALID, 0);
    endtask

    initial begin
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_reg_out_any", |reg_out, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("post_rst_awready", bus.AWREADY, 1);

        // 1: same-cycle AW/W, then read back
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h08, 0);
        // 2: W well ahead of AW, partial strobes
        do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(32'h04, 32'h11223344, 4'h5, 3, 0, 0);
        check("strobe_merge_reg1", reg_out[1*DW +: DW], 32'hAA22CC44);
        // 3: out-of-range write and read
        do_write(32'h100, 32'h12345678, 4'hF, 0, 1, 0);
        do_read(32'h100, 0);
        // 4: B back-pressure
        do_write(32'h14, 32'hCAFEF00D, 4'hF, 1, 0, 5);
        do_write(32'h18, 32'h0BADF00D, 4'hF, 0, 0, 0);

        // 5: write commit and read of reg3 on the same edge
        do_write(32'h0C, 32'h1, 4'hF, 0, 0, 0);
        @(negedge ACLK);
        check("same_edge_awready", bus.AWREADY, 1);
        check("same_edge_arready", bus.ARREADY, 1);
        bus.AWADDR = 32'h0C; bus.WDATA = 32'h2; bus.WSTRB = 4'hF; bus.ARADDR = 32'h0C;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        @(negedge ACLK);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        model[3] = 32'h2;
        check("same_edge_pulse", wr_pulse, NR'(1) << 3);
        check("same_edge_rvalid", bus.RVALID, 1);
        check("same_edge_rdata_old", bus.RDATA, 32'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            if (k == 0) begin
                check("same_edge_bvalid", bus.BVALID, 1);
                bus.BREADY = 1'b1;
            end else if (k == 1) begin
                bus.BREADY = 1'b0;
                check("same_edge_bvalid_drop", bus.BVALID, 0);
            end
            check("same_edge_rvalid_hold", bus.RVALID, 1);
            check("same_edge_rdata_hold", bus.RDATA, 32'h1);
        end
        bus.RREADY = 1'b1;
        @(negedge ACLK);
        bus.RREADY = 1'b0;
        check("same_edge_rvalid_drop", bus.RVALID, 0);
        do_read(32'h0C, 0);

        // 6: asynchronous reset with both responses pending
        do_write(32'h10, 32'h55AA55AA, 4'hF, 0, 0, -1);
        do_read(32'h10, -1);
        #2 ARESETn = 1'b0;
        #1;
        check("arst_bvalid", bus.BVALID, 0);
        check("arst_rvalid", bus.RVALID, 0);
        check("arst_rdata", bus.RDATA, 0);
        check("arst_awready", bus.AWREADY, 0);
        check("arst_reg_out_any", |reg_out, 0);
        for (int i = 0; i < NR; i++) model[i] = 32'd0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        do_write(32'h20, 32'h600DF00D, 4'hF, 0, 0, 0);
        do_read(32'h20, 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) < 8) a = ($urandom_range(0, NR-1) << 2) | $urandom_range(0, 3);
            else if ($urandom_range(0, 1) == 0) a = 32'h40 + ($urandom_range(0, 63) << 2);
            else a = $urandom | 32'h8000_0000;
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
        check_regs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Parametrised AXI-Lite slave that terminates all five AXI-Lite channels and maps them onto a bank of NUM_REGS read/write registers. It is the next generation of the team's AXI-Lite channel set and adds several capabilities:
- byte-lane write strobes (WSTRB)
- a read response code (RRESP)
- independent acceptance of write address and write data
- SLVERR on out-of-range accesses

It sits between the AXI-Lite interconnect and block-level control logic. It exports all register contents and a per-register write pulse.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, data width. Legal values are 32 or 64.
NUM_REGS, 16, number of registers. Range 1..256.
Derived (localparam, not overridable):
- STRB_W = DATA_WIDTH/8
- ADDR_LSB = log2(STRB_W)
- IDX_W = max(1, clog2(NUM_REGS))

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  STRB_W  write byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written

Behaviour:
Clocking and reset:
- Single clock ACLK. Reset ARESETn is asynchronous, active-low, and deasserted synchronously externally.
- While reset is asserted, all outputs are 0: every READY, every VALID, BRESP, RRESP, RDATA, reg_out and wr_pulse.
- Reset mid-transaction discards latched address/data and any pending response. No partial write survives.

Address decode:
- idx = addr[ADDR_LSB +: IDX_W].
- The access is OKAY (2'b00) only if idx < NUM_REGS and all addr bits above ADDR_LSB+IDX_W are 0. Otherwise it returns SLVERR (2'b10).
- addr[ADDR_LSB-1:0] is ignored.

Write path (states W_IDLE, W_RESP):
- W_IDLE:
  - AWREADY = 1 until AW has been accepted; WREADY = 1 until W has been accepted.
  - AW and W are accepted independently, in either order or in the same cycle. AWADDR, WDATA and WSTRB are latched on their respective handshakes.
  - A channel that has already been accepted holds its READY at 0.
- Commit: on the clock edge where both AW and W are held (including the edge of a same-cycle handshake):
  - If decode is OKAY, update byte lane b of register idx only where WSTRB[b] = 1. Lanes with WSTRB[b] = 0 are unchanged.
  - wr_pulse[idx] = 1 for exactly that cycle, even if WSTRB = 0. SLVERR writes change nothing and generate no pulse.
  - The FSM moves to W_RESP.
- Latency: BVALID rises 1 cycle after the commit edge.
- W_RESP:
  - BVALID = 1 and BRESP is stable until BREADY.
  - AWREADY and WREADY are 0.
  - On the BVALID&&BREADY edge: BVALID→0, return to W_IDLE, READYs reassert next cycle.
- Maximum throughput is one write every 3 cycles.

Read path (states R_IDLE, R_DATA), independent of the write path:
- R_IDLE: ARREADY = 1. On handshake, RDATA and RRESP are registered from the current register value, or 0 with SLVERR if out of range. RVALID = 1 from the next cycle (1-cycle latency).
- R_DATA: ARREADY = 0. RDATA, RRESP and RVALID are held stable until RREADY. On the RVALID&&RREADY edge: RVALID→0, return to R_IDLE.

Simultaneous events and ordering:
- A write commit and an AR handshake to the same register on the same edge: the read returns the pre-write value.
- A read accepted on any later edge returns the new value.
- BVALID and RVALID may be active simultaneously; neither channel stalls the other.
- VALID must never depend combinationally on READY in this block. All outputs are registered.

Test Plan:
1. Reset, then AW=0x08 and W=0xDEADBEEF with WSTRB=0xF in the same cycle → wr_pulse[2] one cycle; BVALID next cycle with BRESP=00; read 0x08 → RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR handshake.
2. W (0x11223344, WSTRB=0x5) sent 3 cycles before AW=0x04, with reg1 previously 0xAABBCCDD → WREADY low after W accepted, commit on AW handshake, reg1=0xAA22CC44, single BVALID.
3. Write 0x100 (idx 64 ≥ 16) and read 0x100 → BRESP=10, RRESP=10, RDATA=0, no wr_pulse, all reg_out unchanged.
4. Hold BREADY=0 for 5 cycles after a write → BVALID and BRESP stable, AWREADY=WREADY=0 throughout; second AW/W accepted only after the B handshake.
5. Reg3=0x1, then on the same edge commit write 0x2 to reg3 and complete AR handshake at 0x0C → RDATA=0x1; next read returns 0x2. Hold RREADY=0 for 4 cycles meanwhile → RDATA stable.
6. Assert ARESETn=0 mid-cycle while BVALID=1 and RVALID=1 → both drop asynchronously, reg_out=0; after release, a fresh write/read completes normally.
